// File: rtl/load_store_unit.sv
// Load/store unit: MEM-stage initiator for the word-wide, big-endian data memory.
// Sub-word stores are done as read-modify-write because the memory only writes whole words.
module load_store_unit #(
    parameter int unsigned MEM_BYTES = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clock_enable,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic [3:0] OP_LW  = 4'd0;
    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_SW  = 4'd8;
    localparam logic [3:0] OP_SB  = 4'd9;
    localparam logic [3:0] OP_SH  = 4'd10;

    localparam logic [31:0] LAST_WORD = 32'(MEM_BYTES - 4);

    logic [1:0]  state, nxt_state;
    logic [3:0]  op_q, nxt_op;
    logic [31:0] addr_q, nxt_addr;
    logic [31:0] wdata_q, nxt_wdata;
    logic        idle_q, rd_q, wr_q;
    logic [31:0] maddr_q, nxt_maddr;
    logic [31:0] mwdata_q, nxt_mwdata;
    logic        rvalid_q, rerror_q, nxt_err;
    logic [31:0] rdata_q, nxt_rdata;
    logic        req_bad_c;

    // Extract and extend the addressed byte/halfword of a big-endian word
    function automatic logic [31:0] load_extend(input logic [3:0] op, input logic [1:0] off,
                                                input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        h = off[1] ? word[15:0] : word[31:16];
        case (op)
            OP_LW:   r = word;
            OP_LB:   r = {{24{b[7]}}, b};
            OP_LBU:  r = {24'd0, b};
            OP_LH:   r = {{16{h[15]}}, h};
            OP_LHU:  r = {16'd0, h};
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    // Replace the addressed byte/halfword lane of the read word with store data
    function automatic logic [31:0] store_merge(input logic [3:0] op, input logic [1:0] off,
                                                input logic [31:0] word, input logic [31:0] wd);
        logic [31:0] r;
        r = word;
        if (op == OP_SB) begin
            case (off)
                2'd0:    r[31:24] = wd[7:0];
                2'd1:    r[23:16] = wd[7:0];
                2'd2:    r[15:8]  = wd[7:0];
                default: r[7:0]   = wd[7:0];
            endcase
        end else if (op == OP_SH) begin
            if (off[1]) r[15:0]  = wd[15:0];
            else        r[31:16] = wd[15:0];
        end else begin
            r = wd;
        end
        return r;
    endfunction

    // Illegal op, misalignment or address past the last word
    always_comb begin
        req_bad_c = 1'b0;
        case (req_op)
            OP_LW, OP_SW:          req_bad_c = |req_addr[1:0];
            OP_LH, OP_LHU, OP_SH:  req_bad_c = req_addr[0];
            OP_LB, OP_LBU, OP_SB:  req_bad_c = 1'b0;
            default:               req_bad_c = 1'b1;
        endcase
        if ({req_addr[31:2], 2'b00} > LAST_WORD) req_bad_c = 1'b1;
    end

    // Next state and next registered outputs
    always_comb begin
        nxt_state  = state;
        nxt_op     = op_q;
        nxt_addr   = addr_q;
        nxt_wdata  = wdata_q;
        nxt_err    = 1'b0;
        nxt_rdata  = 32'd0;
        nxt_mwdata = 32'd0;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    nxt_op    = req_op;
                    nxt_addr  = req_addr;
                    nxt_wdata = req_wdata;
                    if (req_bad_c) begin
                        nxt_state = S_RESP;
                        nxt_err   = 1'b1;
                    end else if (req_op == OP_SW) begin
                        nxt_state  = S_WRITE;
                        nxt_mwdata = req_wdata;
                    end else begin
                        nxt_state = S_READ;
                    end
                end
            end
            S_READ: begin
                if (!op_q[3]) begin
                    nxt_state = S_RESP;
                    nxt_rdata = load_extend(op_q, addr_q[1:0], mem_read_data);
                end else begin
                    nxt_state  = S_WRITE;
                    nxt_mwdata = store_merge(op_q, addr_q[1:0], mem_read_data, wdata_q);
                end
            end
            S_WRITE: nxt_state = S_RESP;
            S_RESP:  nxt_state = S_IDLE;
            default: nxt_state = S_IDLE;
        endcase
        nxt_maddr = ((nxt_state == S_READ) || (nxt_state == S_WRITE)) ?
                    {nxt_addr[31:2], 2'b00} : 32'd0;
    end

    // State and output registers; freeze while clock_enable is low
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= S_IDLE;
            op_q     <= 4'd0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            idle_q   <= 1'b1;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            maddr_q  <= 32'd0;
            mwdata_q <= 32'd0;
            rvalid_q <= 1'b0;
            rerror_q <= 1'b0;
            rdata_q  <= 32'd0;
        end else if (clock_enable) begin
            state    <= nxt_state;
            op_q     <= nxt_op;
            addr_q   <= nxt_addr;
            wdata_q  <= nxt_wdata;
            idle_q   <= (nxt_state == S_IDLE);
            rd_q     <= (nxt_state == S_READ);
            wr_q     <= (nxt_state == S_WRITE);
            maddr_q  <= nxt_maddr;
            mwdata_q <= nxt_mwdata;
            rvalid_q <= (nxt_state == S_RESP);
            rerror_q <= nxt_err;
            rdata_q  <= nxt_rdata;
        end
    end

    // Strobes and ready drop immediately on reset or a clock-enable stall
    assign req_ready      = idle_q & reset & clock_enable;
    assign mem_read       = rd_q & reset & clock_enable;
    assign mem_write      = wr_q & reset & clock_enable;
    assign mem_address    = maddr_q;
    assign mem_write_data = mwdata_q;
    assign resp_valid     = rvalid_q;
    assign resp_error     = rerror_q;
    assign resp_rdata     = rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: vector table plus stall and reset-abort sequences.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset, clock_enable, req_valid, req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_error;
    logic [31:0] resp_rdata, mem_address, mem_write_data, mem_read_data;
    logic        mem_read, mem_write;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_BYTES(4096)) dut (
        .clk(clk), .reset(reset), .clock_enable(clock_enable),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
        .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
    );

    // Memory model: combinational read, write on clock edge, bench preload port
    logic [31:0] mem [0:1023];
    logic        pre_en = 1'b0;
    logic [9:0]  pre_idx = 10'd0;
    logic [31:0] pre_word = 32'd0;
    always @(posedge clk) begin
        if (pre_en) mem[pre_idx] <= pre_word;
        else if (mem_write) mem[mem_address[11:2]] <= mem_write_data;
    end
    assign mem_read_data = mem[mem_address[11:2]];

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        do_pre;
        logic [31:0] pre;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_rd;
        int          exp_wr;
        logic [31:0] exp_waddr;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t vecs[20];

    function automatic vec_t mk(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic do_pre, input logic [31:0] pre, input logic [31:0] exp_rdata,
                                input logic exp_err, input int exp_lat, input int exp_rd, input int exp_wr,
                                input logic [31:0] exp_waddr, input logic [31:0] exp_wdata);
        vec_t v;
        v.op = op; v.addr = addr; v.wdata = wdata; v.do_pre = do_pre; v.pre = pre;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = exp_lat;
        v.exp_rd = exp_rd; v.exp_wr = exp_wr; v.exp_waddr = exp_waddr; v.exp_wdata = exp_wdata;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [31:0] addr, input logic [31:0] word);
        @(negedge clk);
        pre_en = 1'b1; pre_idx = addr[11:2]; pre_word = word;
        @(posedge clk);
        #1 pre_en = 1'b0;
    endtask

    // Present a request at a negedge and hold until the accepting edge
    task automatic issue(input string name, input logic [3:0] op, input logic [31:0] addr,
                         input logic [31:0] wdata);
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata;
        #1 check({name, "_ready"}, 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    // Observe bus activity each negedge until resp_valid or the cycle budget expires
    task automatic monitor(input int budget, output int lat, output int rd, output int wr,
                           output int both, output logic [31:0] waddr, output logic [31:0] wdat,
                           output logic [31:0] rdata, output logic err);
        lat = 0; rd = 0; wr = 0; both = 0; waddr = 32'd0; wdat = 32'd0; rdata = 32'd0; err = 1'b0;
        for (int c = 1; c <= budget && lat == 0; c++) begin
            @(negedge clk);
            if (mem_read) rd++;
            if (mem_write) begin wr++; waddr = mem_address; wdat = mem_write_data; end
            if (mem_read && mem_write) both++;
            if (resp_valid) begin lat = c; rdata = resp_rdata; err = resp_error; end
        end
    endtask

    localparam logic [3:0] LW = 4'd0, LB = 4'd1, LBU = 4'd2, LH = 4'd3, LHU = 4'd4;
    localparam logic [3:0] SW = 4'd8, SB = 4'd9, SH = 4'd10;

    initial begin
        int lat, rd, wr, both, seen;
        logic [31:0] waddr, wdat, rdata;
        logic err;
        string nm;

        vecs[0]  = mk(LB,  32'h11,   32'h0,        1, 32'h8899AABB, 32'hFFFFFF99, 0, 2, 1, 0, 0, 0);
        vecs[1]  = mk(LBU, 32'h11,   32'h0,        1, 32'h8899AABB, 32'h00000099, 0, 2, 1, 0, 0, 0);
        vecs[2]  = mk(LH,  32'h12,   32'h0,        1, 32'h8899AABB, 32'hFFFFAABB, 0, 2, 1, 0, 0, 0);
        vecs[3]  = mk(LHU, 32'h10,   32'h0,        1, 32'h8899AABB, 32'h00008899, 0, 2, 1, 0, 0, 0);
        vecs[4]  = mk(LW,  32'h10,   32'h0,        1, 32'h8899AABB, 32'h8899AABB, 0, 2, 1, 0, 0, 0);
        vecs[5]  = mk(LB,  32'h13,   32'h0,        1, 32'h8899AABB, 32'hFFFFFFBB, 0, 2, 1, 0, 0, 0);
        vecs[6]  = mk(LBU, 32'h10,   32'h0,        1, 32'h8899AABB, 32'h00000088, 0, 2, 1, 0, 0, 0);
        vecs[7]  = mk(SB,  32'h12,   32'h000000C3, 1, 32'h8899AABB, 32'h0, 0, 3, 1, 1, 32'h10, 32'h8899C3BB);
        vecs[8]  = mk(SH,  32'h12,   32'h00001234, 1, 32'h8899AABB, 32'h0, 0, 3, 1, 1, 32'h10, 32'h88991234);
        vecs[9]  = mk(SB,  32'h10,   32'h0000007F, 1, 32'h8899AABB, 32'h0, 0, 3, 1, 1, 32'h10, 32'h7F99AABB);
        vecs[10] = mk(SH,  32'h10,   32'hFFFFABCD, 1, 32'h8899AABB, 32'h0, 0, 3, 1, 1, 32'h10, 32'hABCDAABB);
        vecs[11] = mk(SW,  32'h20,   32'hDEADBEEF, 0, 32'h0,        32'h0, 0, 2, 0, 1, 32'h20, 32'hDEADBEEF);
        vecs[12] = mk(LW,  32'h20,   32'h0,        0, 32'h0,        32'hDEADBEEF, 0, 2, 1, 0, 0, 0);
        vecs[13] = mk(LW,  32'h13,   32'h0,        0, 32'h0,        32'h0, 1, 1, 0, 0, 0, 0);
        vecs[14] = mk(LH,  32'h11,   32'h0,        0, 32'h0,        32'h0, 1, 1, 0, 0, 0, 0);
        vecs[15] = mk(LW,  32'h1000, 32'h0,        0, 32'h0,        32'h0, 1, 1, 0, 0, 0, 0);
        vecs[16] = mk(4'd5, 32'h10,  32'h0,        0, 32'h0,        32'h0, 1, 1, 0, 0, 0, 0);
        vecs[17] = mk(LW,  32'hFFC,  32'h0,        1, 32'h01234567, 32'h01234567, 0, 2, 1, 0, 0, 0);
        vecs[18] = mk(SB,  32'h1000, 32'h55,       0, 32'h0,        32'h0, 1, 1, 0, 0, 0, 0);
        vecs[19] = mk(LBU, 32'hFFF,  32'h0,        1, 32'h01234567, 32'h00000067, 0, 2, 1, 0, 0, 0);

        reset = 1'b0; clock_enable = 1'b1; req_valid = 1'b0;
        req_op = 4'd0; req_addr = 32'd0; req_wdata = 32'd0;

        // Reset held for two cycles: all outputs low
        repeat (2) begin
            @(negedge clk);
            check("rst_ready",  32'(req_ready),  32'd0);
            check("rst_rvalid", 32'(resp_valid), 32'd0);
            check("rst_rerror", 32'(resp_error), 32'd0);
            check("rst_rdata",  resp_rdata,      32'd0);
            check("rst_mread",  32'(mem_read),   32'd0);
            check("rst_mwrite", 32'(mem_write),  32'd0);
            check("rst_maddr",  mem_address,     32'd0);
            check("rst_mwdata", mem_write_data,  32'd0);
        end
        reset = 1'b1;
        #1 check("post_rst_ready", 32'(req_ready), 32'd1);

        // Directed vector table
        foreach (vecs[i]) begin
            nm = $sformatf("v%0d", i);
            if (vecs[i].do_pre) preload(vecs[i].addr, vecs[i].pre);
            issue(nm, vecs[i].op, vecs[i].addr, vecs[i].wdata);
            monitor(10, lat, rd, wr, both, waddr, wdat, rdata, err);
            check({nm, "_lat"},   32'(lat),   32'(vecs[i].exp_lat));
            check({nm, "_rdata"}, rdata,      vecs[i].exp_rdata);
            check({nm, "_err"},   32'(err),   32'(vecs[i].exp_err));
            check({nm, "_nread"}, 32'(rd),    32'(vecs[i].exp_rd));
            check({nm, "_nwrite"}, 32'(wr),   32'(vecs[i].exp_wr));
            check({nm, "_both"},  32'(both),  32'd0);
            if (vecs[i].exp_wr != 0) begin
                check({nm, "_waddr"}, waddr, vecs[i].exp_waddr);
                check({nm, "_wdata"}, wdat,  vecs[i].exp_wdata);
            end
            @(negedge clk);
            check({nm, "_pulse"},     32'(resp_valid), 32'd0);
            check({nm, "_ready_ret"}, 32'(req_ready),  32'd1);
        end

        // Clock-enable stall during SB READ; memory changes while stalled
        preload(32'h10, 32'h8899AABB);
        issue("ce", SB, 32'h12, 32'h000000C3);
        @(negedge clk);
        check("ce_read_before", 32'(mem_read), 32'd1);
        clock_enable = 1'b0;
        pre_en = 1'b1; pre_idx = 10'd4; pre_word = 32'h11223344;
        #1 check("ce_stall0_read", 32'(mem_read), 32'd0);
        check("ce_stall0_write", 32'(mem_write), 32'd0);
        @(posedge clk);
        #1 pre_en = 1'b0;
        for (int k = 1; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("ce_stall%0d_read", k),  32'(mem_read),   32'd0);
            check($sformatf("ce_stall%0d_write", k), 32'(mem_write),  32'd0);
            check($sformatf("ce_stall%0d_resp", k),  32'(resp_valid), 32'd0);
        end
        @(negedge clk);
        clock_enable = 1'b1;
        #1 check("ce_resume_read", 32'(mem_read), 32'd1);
        monitor(10, lat, rd, wr, both, waddr, wdat, rdata, err);
        check("ce_lat",   32'(lat), 32'd2);
        check("ce_nwrite", 32'(wr), 32'd1);
        check("ce_waddr", waddr,    32'h10);
        check("ce_wdata", wdat,     32'h1122C344);
        check("ce_err",   32'(err), 32'd0);

        // Reset asserted during SB WRITE: no write, no response
        preload(32'h10, 32'h8899AABB);
        issue("ra", SB, 32'h12, 32'h000000C3);
        @(negedge clk);
        check("ra_read", 32'(mem_read), 32'd1);
        @(negedge clk);
        check("ra_write_before", 32'(mem_write), 32'd1);
        reset = 1'b0;
        #1 check("ra_write_gated", 32'(mem_write), 32'd0);
        @(posedge clk);
        #1 check("ra_mem_kept", mem[4], 32'h8899AABB);
        @(negedge clk);
        check("ra_rvalid_rst", 32'(resp_valid), 32'd0);
        reset = 1'b1;
        #1 check("ra_ready", 32'(req_ready), 32'd1);
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (resp_valid || mem_write || mem_read) seen++;
        end
        check("ra_quiet", 32'(seen), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
